dlsc_demosaic_vng6_grad_select: RTL
===================================

# dlsc_demosaic_vng6_grad_select

Threshold-and-average stage of the VNG6 green path, directly downstream of the diagonal-green stage. Per output pixel it collects eight directional gradients and eight directional green estimates in matching direction order. It computes a VNG threshold from the gradient min/max, sums the greens whose gradient passes the threshold, and divides by the pass count with a sequential restoring divider. The result is the final interpolated green value for the pixel.

## Interface
Parameters:
- DATA, 8, pixel width; green estimates are DATA+1 bits (normalized diagonal-green format)
- GRAD, DATA+4, gradient width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- clk_en  in  1  global enable; when low all state, counters and outputs hold
- grad_push  in  1  gradient input valid, one direction per enabled cycle
- grad_in  in  GRAD  gradient for current direction index
- green_push  in  1  green estimate valid (fed from diag_green_push)
- green_in  in  DATA+1  green estimate for current direction index
- out_valid  out  1  one-enabled-cycle pulse, result valid
- out_green  out  DATA+1  averaged green, floor(sum/count)
- out_count  out  4  number of passing directions, 1..8
- err_overrun  out  1  sticky protocol error, cleared only by reset

## Operation
- States: GRAD, GREEN, DIV. Reset state is GRAD with direction index 0.
- All flops reset asynchronously on rst_n low: out_valid=0, out_green=0, out_count=0, err_overrun=0, min/max/sum/count=0.
- GRAD state:
  - Each accepted grad_push stores grad_in into a gradient register file entry[idx] and increments idx.
  - On first entry (idx=0), min and max are loaded with grad_in; later entries use min=min(min,grad_in) and max=max(max,grad_in).
  - On the 8th push, idx wraps to 0, the state moves to GREEN, and threshold T is registered on the same edge from the final min/max.
- Threshold: T = min + ((max−min)>>1), GRAD bits. No overflow is possible.
- GREEN state:
  - Each accepted green_push compares entry[idx] <= T; ties pass.
  - On pass, sum += green_in (DATA+4 bits, cannot overflow) and count += 1.
  - idx increments. The 8th push moves the state to DIV.
  - count ≥ 1 always, because the min gradient always passes.
- DIV state:
  - Restoring division of sum by count, one quotient bit per enabled cycle, MSB first, DATA+4 iterations.
  - On the last iteration edge: out_green = quotient[DATA:0], out_count = count, out_valid = 1, state returns to GRAD, and sum/count are cleared.
  - The quotient never exceeds the maximum green value, so truncation to DATA+1 bits is lossless.
- out_valid clears on the next enabled edge. out_green and out_count hold until the next result.
- Protocol errors:
  - grad_push outside GRAD, or green_push outside GREEN, is dropped and sets err_overrun. State and data are unaffected.
  - If grad_push and green_push arrive in the same GRAD cycle, grad is accepted and green is dropped with the error set.
- Reset mid-operation aborts the pixel with no out_valid. The next pushes start a new pixel at idx 0.

## Timing
- Input acceptance: same edge as push with clk_en high. No backpressure; upstream cadence must allow DIV to complete.
- Latency: the 8th green is accepted at enabled edge E0. out_valid is high from enabled edge E(DATA+4) until E(DATA+5). This is 12 enabled cycles for DATA=8.
- A grad_push is accepted again on edge E(DATA+5) or later.
- Minimum pixel period: 8 + 8 + (DATA+4) enabled cycles.
- clk_en low stretches every phase cycle-for-cycle. Stalls do not affect the result.

## Test plan
- DATA=8; grads 10,20,30,40,50,60,70,80; greens 100,104,108,112,400,400,400,400 -> T=45, out_count=4, out_green=106, out_valid exactly one enabled cycle, 12 enabled cycles after the last green.
- All grads 5; all greens 511 -> out_count=8, out_green=511 (max value, no truncation error).
- Grads 0,0,0,100,100,100,100,100; greens 10,10,11,x… -> T=50, count=3, sum=31, out_green=10 (floor).
- grad_push during DIV, and green_push during GRAD -> err_overrun=1 and stays 1; the in-flight result is unchanged. The following well-formed pixel is correct.
- Random clk_en duty (about 50%) over 1000 random pixels -> results match a reference model, and latency counted in enabled cycles is constant.
- rst_n pulsed mid-GREEN and mid-DIV -> all outputs 0 immediately, no out_valid. The next full pixel produces the correct result.

Source files
------------

// File: rtl/dlsc_demosaic_vng6_grad_select.sv
// VNG6 green threshold-and-average: collects 8 gradients then 8 greens, averages the passing greens.
// Result appears DATA+4 enabled cycles after the last green; no backpressure, so upstream paces pixels.
module dlsc_demosaic_vng6_grad_select #(
  parameter int DATA = 8,
  parameter int GRAD = DATA + 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clk_en,
  input  logic            grad_push,
  input  logic [GRAD-1:0] grad_in,
  input  logic            green_push,
  input  logic [DATA:0]   green_in,
  output logic            out_valid,
  output logic [DATA:0]   out_green,
  output logic [3:0]      out_count,
  output logic            err_overrun
);

  localparam int SUMW = DATA + 4;
  localparam int DIVN = DATA + 4;
  localparam int DCW  = $clog2(DIVN + 1);

  typedef enum logic [1:0] {ST_GRAD, ST_GREEN, ST_DIV} state_t;

  state_t            state, state_nxt;
  logic [2:0]        idx;
  logic [GRAD-1:0]   grads [8];
  logic [GRAD-1:0]   gmin, gmax, thresh;
  logic [SUMW-1:0]   sum;
  logic [3:0]        count;
  logic [3:0]        rem;
  logic [DCW-1:0]    div_cnt;

  logic              grad_acc, green_acc, err_set;
  logic [GRAD-1:0]   nmin, nmax, thresh_nxt;
  logic              green_pass;
  logic [SUMW-1:0]   sum_nxt;
  logic [3:0]        count_nxt;
  logic [4:0]        rem_sh, rem_sub;
  logic              rem_ge;
  logic [SUMW-1:0]   quo_nxt;
  logic              last_iter;

  assign grad_acc  = clk_en && grad_push  && (state == ST_GRAD);
  assign green_acc = clk_en && green_push && (state == ST_GREEN);
  assign err_set   = clk_en && ((grad_push && (state != ST_GRAD)) ||
                                (green_push && (state != ST_GREEN)));

  // First direction seeds min/max so no sentinel values are needed.
  assign nmin       = (idx == 3'd0 || grad_in < gmin) ? grad_in : gmin;
  assign nmax       = (idx == 3'd0 || grad_in > gmax) ? grad_in : gmax;
  assign thresh_nxt = nmin + ((nmax - nmin) >> 1);

  assign green_pass = (grads[idx] <= thresh);
  assign sum_nxt    = green_pass ? sum + {{(SUMW-DATA-1){1'b0}}, green_in} : sum;
  assign count_nxt  = green_pass ? count + 4'd1 : count;

  // Restoring divide step; sum doubles as the dividend/quotient shift register.
  assign rem_sh    = {rem, sum[SUMW-1]};
  assign rem_ge    = (rem_sh >= {1'b0, count});
  assign rem_sub   = rem_sh - {1'b0, count};
  assign quo_nxt   = {sum[SUMW-2:0], rem_ge};
  assign last_iter = (div_cnt == DCW'(DIVN - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      ST_GRAD:  if (grad_acc && idx == 3'd7)  state_nxt = ST_GREEN;
      ST_GREEN: if (green_acc && idx == 3'd7) state_nxt = ST_DIV;
      ST_DIV:   if (clk_en && last_iter)      state_nxt = ST_GRAD;
      default:  state_nxt = ST_GRAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_GRAD;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= '0;
      gmin        <= '0;
      gmax        <= '0;
      thresh      <= '0;
      sum         <= '0;
      count       <= '0;
      rem         <= '0;
      div_cnt     <= '0;
      out_valid   <= 1'b0;
      out_green   <= '0;
      out_count   <= '0;
      err_overrun <= 1'b0;
      for (int i = 0; i < 8; i++) grads[i] <= '0;
    end else if (clk_en) begin
      out_valid <= 1'b0;
      if (err_set) err_overrun <= 1'b1;
      if (grad_acc) begin
        grads[idx] <= grad_in;
        gmin       <= nmin;
        gmax       <= nmax;
        idx        <= idx + 3'd1;
        if (idx == 3'd7) thresh <= thresh_nxt;
      end
      if (green_acc) begin
        sum   <= sum_nxt;
        count <= count_nxt;
        idx   <= idx + 3'd1;
        if (idx == 3'd7) begin
          rem     <= '0;
          div_cnt <= '0;
        end
      end
      if (state == ST_DIV) begin
        rem     <= rem_ge ? rem_sub[3:0] : rem_sh[3:0];
        sum     <= quo_nxt;
        div_cnt <= div_cnt + DCW'(1);
        if (last_iter) begin
          out_green <= quo_nxt[DATA:0];
          out_count <= count;
          out_valid <= 1'b1;
          sum       <= '0;
          count     <= '0;
        end
      end
    end
  end

endmodule
